// File: rtl/seg7_pkg.sv
// Shared constants, segment table and state type for the 7-segment trace display.
package seg7_pkg;

    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned IDX_W      = 3;
    localparam int unsigned NIB_W      = 4;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned SEG_W      = 8;

    localparam logic [SEG_W-1:0] SEG_OFF = 8'hFF;

    // Active-low g..a patterns, entry 0 at the LSB end
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef enum logic {BLANK, RUN} state_t;

endpackage

// File: rtl/seg7_trace_display_if.sv
// Trace-in / display-out bundle between the CPU trace taps and the 7-segment display.
interface seg7_trace_display_if;
    import seg7_pkg::*;

    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] inst;
    logic              sel;
    logic              freeze;
    logic [SEG_W-1:0]  an;
    logic [SEG_W-1:0]  seg;

    modport master (output pc, inst, sel, freeze, input an, seg);
    modport slave  (input pc, inst, sel, freeze, output an, seg);

endinterface

// File: rtl/hex7seg_decode.sv
// Combinational nibble to active-low g..a segment decoder, shared by board displays.
module hex7seg_decode
    import seg7_pkg::*;
(
    input  logic [NIB_W-1:0] i_nib,
    output logic [6:0]       o_seg_c
);

    assign o_seg_c = HEX_SEG[i_nib];

endmodule

// File: rtl/seg7_trace_display.sv
// Time-multiplexed 8-digit hex display of the CPU pc/inst trace, snapshotted per frame.
// Optional leading-zero blanking is enabled by defining SEG_LZB_EN.
module seg7_trace_display
    import seg7_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100000
) (
    input  logic                 clk_in,
    input  logic                 reset,
    seg7_trace_display_if.slave  bus
);

    localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    state_t              r_state;
    logic [PRESC_W-1:0]  r_presc;
    logic [IDX_W-1:0]    r_idx;
    logic [DATA_W-1:0]   r_shadow;
    logic                r_sel_q;
    logic [SEG_W-1:0]    r_an;
    logic [SEG_W-1:0]    r_seg;

    logic                w_tick;
    logic                w_frame_ev;
    logic [NIB_W-1:0]    w_nib;
    logic [6:0]          w_hex;
    logic                w_dp;
    logic [DATA_W-1:0]   w_snap;
    logic [NUM_DIGITS-1:0] w_keep;
    logic                w_show;

    assign w_tick     = (r_presc == PRESC_W'(TICK_DIV - 1));
    assign w_frame_ev = w_tick && (r_idx == IDX_W'(NUM_DIGITS - 1));
    assign w_nib      = r_shadow[{r_idx, 2'b00} +: NIB_W];
    assign w_dp       = !((r_idx == '0) && r_sel_q);
    assign w_snap     = bus.sel ? bus.inst : bus.pc;
    assign w_show     = w_keep[r_idx];

    hex7seg_decode u_dec (
        .i_nib   (w_nib),
        .o_seg_c (w_hex)
    );

`ifdef SEG_LZB_EN
    // Keep a digit when it or any higher nibble is non-zero; digit 0 always shows
    always_comb begin
        logic w_any;
        w_any  = 1'b0;
        w_keep = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_any     = w_any | (|r_shadow[4*i +: NIB_W]);
            w_keep[i] = w_any;
        end
        w_keep[0] = 1'b1;
    end
`else
    assign w_keep = '1;
`endif

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state  <= BLANK;
            r_presc  <= '0;
            r_idx    <= '0;
            r_shadow <= '0;
            r_sel_q  <= 1'b0;
            r_an     <= SEG_OFF;
            r_seg    <= SEG_OFF;
        end else begin
            case (r_state)
                BLANK: begin
                    // Start-up capture doubles as the first frame boundary
                    if (!bus.freeze) begin
                        r_shadow <= w_snap;
                        r_sel_q  <= bus.sel;
                    end
                    r_presc <= '0;
                    r_idx   <= '0;
                    r_an    <= SEG_OFF;
                    r_seg   <= SEG_OFF;
                    r_state <= RUN;
                end
                RUN: begin
                    r_presc <= w_tick ? '0 : r_presc + PRESC_W'(1);
                    if (w_tick) begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                    if (w_frame_ev && !bus.freeze) begin
                        r_shadow <= w_snap;
                        r_sel_q  <= bus.sel;
                    end
                    if (w_show) begin
                        r_an  <= ~(SEG_W'(1) << r_idx);
                        r_seg <= {w_dp, w_hex};
                    end else begin
                        r_an  <= SEG_OFF;
                        r_seg <= SEG_OFF;
                    end
                end
                default: begin
                    r_state <= BLANK;
                end
            endcase
        end
    end

    assign bus.an  = r_an;
    assign bus.seg = r_seg;

endmodule
